// File: rtl/csel_adder_pipe.sv
// ---------------------------------------------------------------------------
// csel_adder_pipe
//   Two-stage pipelined carry-select adder/subtractor.
//   Stage 1 computes segment 0 with the true carry-in.
//   For every other SEG-bit segment, stage 1 precomputes the sum and
//   carry-out for both carry-in values.
//   Stage 2 resolves the segment carry chain through select muxes.
//   It then applies wrap or signed-saturation mode and registers the result.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (combinational from out_ready)
//   a, b       operands, WIDTH bits
//   cin        carry-in (add) / borrow-in (sub)
//   op         00 add, 01 sub, 10 signed sat add, 11 signed sat sub
//   out_valid  result beat valid
//   out_ready  downstream accepts result
//   sum        result, WIDTH bits
//   cout       raw carry-out of the top segment
//   of         signed overflow of the unsaturated result
//   zero       final (post-saturation) sum is zero
//   sat        saturation was applied
// ---------------------------------------------------------------------------
module csel_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             of,
  output logic             zero,
  output logic             sat
);

  localparam int NSEG = WIDTH / SEG;

  // Handshake
  logic s1_valid_q, s2_valid_q;
  logic adv1, adv2, accept;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;

  // Stage 1: operand conditioning and per-segment dual-carry sums
  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;
  logic [SEG-1:0]     seg0_sum_d;
  logic               seg0_c_d;
  logic [WIDTH-1:SEG] sum0_d, sum1_d;
  logic [NSEG-1:1]    cout0_d, cout1_d;

  always_comb begin
    // Subtraction is a + ~b + ~borrow
    b_eff = op[0] ? ~b : b;
    c_eff = op[0] ? ~cin : cin;
    {seg0_c_d, seg0_sum_d} = {1'b0, a[SEG-1:0]} + {1'b0, b_eff[SEG-1:0]}
                           + {{SEG{1'b0}}, c_eff};
    sum0_d  = '0;
    sum1_d  = '0;
    cout0_d = '0;
    cout1_d = '0;
    for (int k = 1; k < NSEG; k++) begin
      {cout0_d[k], sum0_d[k*SEG +: SEG]} = {1'b0, a[k*SEG +: SEG]}
                                         + {1'b0, b_eff[k*SEG +: SEG]};
      {cout1_d[k], sum1_d[k*SEG +: SEG]} = {1'b0, a[k*SEG +: SEG]}
                                         + {1'b0, b_eff[k*SEG +: SEG]}
                                         + {{SEG{1'b0}}, 1'b1};
    end
  end

  logic [SEG-1:0]     s1_seg0_sum_q;
  logic               s1_seg0_c_q;
  logic [WIDTH-1:SEG] s1_sum0_q, s1_sum1_q;
  logic [NSEG-1:1]    s1_cout0_q, s1_cout1_q;
  logic               s1_a_msb_q, s1_b_msb_q, s1_sat_op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_seg0_sum_q <= '0;
      s1_seg0_c_q   <= 1'b0;
      s1_sum0_q     <= '0;
      s1_sum1_q     <= '0;
      s1_cout0_q    <= '0;
      s1_cout1_q    <= '0;
      s1_a_msb_q    <= 1'b0;
      s1_b_msb_q    <= 1'b0;
      s1_sat_op_q   <= 1'b0;
    end else begin
      if (adv1) s1_valid_q <= in_valid;
      if (accept) begin
        s1_seg0_sum_q <= seg0_sum_d;
        s1_seg0_c_q   <= seg0_c_d;
        s1_sum0_q     <= sum0_d;
        s1_sum1_q     <= sum1_d;
        s1_cout0_q    <= cout0_d;
        s1_cout1_q    <= cout1_d;
        s1_a_msb_q    <= a[WIDTH-1];
        s1_b_msb_q    <= b_eff[WIDTH-1];
        s1_sat_op_q   <= op[1];
      end
    end
  end

  // Stage 2: carry-select resolution, overflow and saturation
  logic [WIDTH-1:0] raw_sum, sat_val, sum_d;
  logic             carry, cout_d, of_d, sat_d, zero_d;

  always_comb begin
    carry                = s1_seg0_c_q;
    raw_sum              = '0;
    raw_sum[SEG-1:0]     = s1_seg0_sum_q;
    for (int k = 1; k < NSEG; k++) begin
      raw_sum[k*SEG +: SEG] = carry ? s1_sum1_q[k*SEG +: SEG] : s1_sum0_q[k*SEG +: SEG];
      carry                 = carry ? s1_cout1_q[k] : s1_cout0_q[k];
    end
    cout_d  = carry;
    of_d    = (s1_a_msb_q == s1_b_msb_q) && (raw_sum[WIDTH-1] != s1_a_msb_q);
    sat_d   = s1_sat_op_q && of_d;
    // Overflow direction follows the sign of a: positive clamps to max, negative to min
    sat_val = {s1_a_msb_q, {(WIDTH-1){~s1_a_msb_q}}};
    sum_d   = sat_d ? sat_val : raw_sum;
    zero_d  = (sum_d == '0);
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, of_q, zero_q, sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      of_q       <= 1'b0;
      zero_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      // Bubbles advance the valid bit only; result fields keep the last beat
      if (s1_valid_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        of_q   <= of_d;
        zero_q <= zero_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign of        = of_q;
  assign zero      = zero_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
`timescale 1ns/1ps
module tb_csel_adder_pipe;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        of;
    logic        zero;
    logic        sat;
  } res_t;
  typedef res_t [2:0] res3_t;   // [0]=16/4, [1]=32/8, [2]=64/16

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a, b;
  logic        cin;
  logic [1:0]  op;
  logic        out_ready;

  logic        in_ready16, in_ready32, in_ready64;
  logic        out_valid16, out_valid32, out_valid64;
  logic [15:0] sum16;
  logic [31:0] sum32;
  logic [63:0] sum64;
  logic        cout16, cout32, cout64, of16, of32, of64;
  logic        zero16, zero32, zero64, sat16, sat32, sat64;

  int    n_checks = 0;
  int    n_fail   = 0;
  res3_t sbq[$];

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .op(op),
    .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
    .cout(cout16), .of(of16), .zero(zero16), .sat(sat16));

  csel_adder_pipe #(.WIDTH(32), .SEG(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .op(op),
    .out_valid(out_valid32), .out_ready(out_ready), .sum(sum32),
    .cout(cout32), .of(of32), .zero(zero32), .sat(sat32));

  csel_adder_pipe #(.WIDTH(64), .SEG(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid64), .out_ready(out_ready), .sum(sum64),
    .cout(cout64), .of(of64), .zero(zero64), .sat(sat64));

  function automatic int wid(input int i);
    return (i == 0) ? 16 : (i == 1) ? 32 : 64;
  endfunction

  // Arithmetic reference: exact signed/unsigned results, then reduce to w bits
  function automatic res_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic c, input logic [1:0] o);
    logic [67:0]        mask, ua, ub, ut, uc;
    logic signed [67:0] sa, sb, sc, ex, smax, smin;
    res_t               r;
    mask = (68'd1 << w) - 68'd1;
    ua   = {4'b0, av} & mask;
    ub   = {4'b0, bv} & mask;
    uc   = {67'b0, c};
    sc   = {67'b0, c};
    sa   = ua;
    if (ua[w-1]) sa = sa - $signed(68'd1 << w);
    sb   = ub;
    if (ub[w-1]) sb = sb - $signed(68'd1 << w);
    smax = $signed((68'd1 << (w-1)) - 68'd1);
    smin = -smax - 68'sd1;
    if (o[0]) begin
      ex = sa - sb - sc;
      ut = ua + (68'd1 << w) - ub - uc;
    end else begin
      ex = sa + sb + sc;
      ut = ua + ub + uc;
    end
    r.of   = (ex > smax) || (ex < smin);
    r.cout = ut[w];
    r.sat  = o[1] && r.of;
    if (r.sat) r.sum = ((ex > 0) ? smax[63:0] : smin[63:0]) & mask[63:0];
    else       r.sum = ex[63:0] & mask[63:0];
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  // One clock of stimulus; pushes the expected result of any accepted beat
  task automatic drive(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                       input logic c, input logic [1:0] o, input logic ordy,
                       output logic acc, output logic fire, output res3_t obs,
                       output logic [2:0] ov3, output logic rdy);
    res3_t e;
    @(negedge clk);
    in_valid = iv; a = av; b = bv; cin = c; op = o; out_ready = ordy;
    #1;
    rdy    = in_ready32;
    acc    = iv && in_ready32;
    ov3    = {out_valid64, out_valid32, out_valid16};
    fire   = out_valid32 && ordy;
    obs[0] = {{48'd0, sum16}, cout16, of16, zero16, sat16};
    obs[1] = {{32'd0, sum32}, cout32, of32, zero32, sat32};
    obs[2] = {sum64, cout64, of64, zero64, sat64};
    if (acc) begin
      e[0] = model(16, av, bv, c, o);
      e[1] = model(32, av, bv, c, o);
      e[2] = model(64, av, bv, c, o);
      sbq.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid64, out_valid32, out_valid16} !== 3'b000) begin
      n_fail++; $display("FAIL reset_out_valid: got %b, want 000", {out_valid64, out_valid32, out_valid16});
    end
    n_checks++;
    if ({sum64, sum32, sum16} !== 112'd0) begin
      n_fail++; $display("FAIL reset_sum: got %h/%h/%h, want 0", sum16, sum32, sum64);
    end
    n_checks++;
    if ({cout16, of16, zero16, sat16, cout32, of32, zero32, sat32, cout64, of64, zero64, sat64} !== 12'd0) begin
      n_fail++; $display("FAIL reset_flags: got nonzero flags, want all 0");
    end
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, want 1", in_ready32);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [31:0] ta [6] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd0, 32'h80000000};
    logic [31:0] tb [6] = '{32'd1, 32'd1, 32'd0, 32'd3, 32'd1, 32'd1};
    logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  to [6] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic [31:0] ts [6] = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'd2, 32'hFFFFFFFF, 32'h80000000};
    logic [3:0]  tf [6] = '{4'b0100, 4'b0101, 4'b1010, 4'b1000, 4'b0000, 4'b1101}; // cout,of,zero,sat
    logic acc, fire, rdy; logic [2:0] ov3; res3_t obs, exp;
    int lat; bit got;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, {32'd0, ta[i]}, {32'd0, tb[i]}, tc[i], to[i], 1'b1, acc, fire, obs, ov3, rdy);
      n_checks++;
      if (acc !== 1'b1) begin n_fail++; $display("FAIL directed_accept[%0d]: got %b, want 1", i, acc); end
      lat = 0; got = 0;
      while (!got && lat < 10) begin
        drive(1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1, acc, fire, obs, ov3, rdy);
        lat++;
        if (fire) begin
          got = 1;
          n_checks++;
          if (sbq.size() == 0) begin
            n_fail++; $display("FAIL directed_spurious[%0d]: got sum32=%h, want no result", i, obs[1].sum);
          end else begin
            exp = sbq.pop_front();
            for (int w = 0; w < 3; w++) begin
              n_checks++;
              if (obs[w] !== exp[w]) begin
                n_fail++;
                $display("FAIL directed_model[%0d] w%0d: got %h c%b o%b z%b s%b, want %h c%b o%b z%b s%b",
                         i, wid(w), obs[w].sum, obs[w].cout, obs[w].of, obs[w].zero, obs[w].sat,
                         exp[w].sum, exp[w].cout, exp[w].of, exp[w].zero, exp[w].sat);
              end
            end
          end
          n_checks++;
          if (obs[1].sum[31:0] !== ts[i]) begin
            n_fail++; $display("FAIL directed_sum[%0d]: got %h, want %h", i, obs[1].sum[31:0], ts[i]);
          end
          n_checks++;
          if ({obs[1].cout, obs[1].of, obs[1].zero, obs[1].sat} !== tf[i]) begin
            n_fail++; $display("FAIL directed_flags[%0d]: got %b, want %b", i,
                               {obs[1].cout, obs[1].of, obs[1].zero, obs[1].sat}, tf[i]);
          end
        end
      end
      n_checks++;
      if (!got || lat != 2) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d (seen=%0d), want 2", i, lat, got);
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic acc, fire, rdy; logic [2:0] ov3; res3_t obs, exp;
    int lat; bit got;
    drive(1'b1, 64'h1111, 64'h2222, 1'b0, 2'b00, 1'b1, acc, fire, obs, ov3, rdy);
    drive(1'b1, 64'h3333, 64'h4444, 1'b1, 2'b01, 1'b1, acc, fire, obs, ov3, rdy);
    @(negedge clk); #1;
    n_checks++;
    if (out_valid32 !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b, want 1", out_valid32); end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid64, out_valid32, out_valid16} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_out_valid: got %b, want 000", {out_valid64, out_valid32, out_valid16});
    end
    n_checks++;
    if ({sum64, sum32, sum16, cout32, of32, zero32, sat32} !== 116'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got sum32=%h flags=%b, want 0", sum32, {cout32, of32, zero32, sat32});
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 64'h7FFF_0000_7FFF_0010, 64'h0000_0001_0000_0020, 1'b1, 2'b10, 1'b1, acc, fire, obs, ov3, rdy);
    n_checks++;
    if (fire !== 1'b0 || acc !== 1'b1) begin
      n_fail++; $display("FAIL midrst_first_accept: got acc=%b fire=%b, want acc=1 fire=0", acc, fire);
    end
    lat = 0; got = 0;
    while (!got && lat < 10) begin
      drive(1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1, acc, fire, obs, ov3, rdy);
      lat++;
      if (fire) begin
        got = 1;
        exp = sbq.pop_front();
        for (int w = 0; w < 3; w++) begin
          n_checks++;
          if (obs[w] !== exp[w]) begin
            n_fail++; $display("FAIL midrst_result w%0d: got %h, want %h", wid(w), obs[w].sum, exp[w].sum);
          end
        end
      end
    end
    n_checks++;
    if (!got || lat != 2) begin
      n_fail++; $display("FAIL midrst_latency: got %0d (seen=%0d), want 2", lat, got);
    end
  endtask

  task automatic test_backpressure;
    logic acc, fire, rdy, ordy, held; logic [2:0] ov3; res3_t obs, exp, hold_obs;
    int n_acc, n_got, sent, cyc;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'b0,
            acc, fire, obs, ov3, rdy);
      if (acc) n_acc++;
      if (i == 2) begin
        hold_obs = obs;
        n_checks++;
        if (ov3 !== 3'b111) begin n_fail++; $display("FAIL fill_out_valid: got %b, want 111", ov3); end
      end
      if (i > 2) begin
        n_checks++;
        if (obs !== hold_obs) begin n_fail++; $display("FAIL fill_hold: got sum32=%h, want %h", obs[1].sum, hold_obs[1].sum); end
      end
    end
    n_checks++;
    if (n_acc != 2) begin n_fail++; $display("FAIL fill_accepts: got %0d, want 2", n_acc); end
    n_checks++;
    if (rdy !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b, want 0", rdy); end

    sent = 0; n_got = 0; cyc = 0; held = 0;
    while ((sent < 8 || sbq.size() != 0) && cyc < 200) begin
      ordy = 1'($urandom);
      drive(sent < 8, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom), ordy,
            acc, fire, obs, ov3, rdy);
      cyc++;
      if (acc) sent++;
      if (held) begin
        n_checks++;
        if (obs !== hold_obs || ov3 !== 3'b111) begin
          n_fail++; $display("FAIL bp_hold: got sum32=%h valid=%b, want %h valid=111", obs[1].sum, ov3, hold_obs[1].sum);
        end
      end
      held = ov3[1] && !ordy;
      hold_obs = obs;
      if (fire) begin
        n_got++;
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL bp_spurious: got sum32=%h, want no result", obs[1].sum);
        end else begin
          exp = sbq.pop_front();
          for (int w = 0; w < 3; w++) begin
            n_checks++;
            if (obs[w] !== exp[w]) begin
              n_fail++; $display("FAIL bp_result w%0d: got %h c%b o%b z%b s%b, want %h c%b o%b z%b s%b", wid(w),
                                 obs[w].sum, obs[w].cout, obs[w].of, obs[w].zero, obs[w].sat,
                                 exp[w].sum, exp[w].cout, exp[w].of, exp[w].zero, exp[w].sat);
            end
          end
        end
      end
    end
    n_checks++;
    if (n_got != 10 || sbq.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d results (%0d pending), want 10 (0 pending)", n_got, sbq.size());
    end
  endtask

  task automatic test_back_to_back;
    logic acc, fire, rdy; logic [2:0] ov3; res3_t obs, exp;
    int n_acc, n_got, cyc, first, last;
    n_acc = 0; n_got = 0; cyc = 0; first = -1; last = -1;
    while ((n_acc < 20 || sbq.size() != 0) && cyc < 60) begin
      drive(n_acc < 20, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'b1,
            acc, fire, obs, ov3, rdy);
      if (acc) n_acc++;
      if (fire) begin
        n_got++;
        if (first < 0) first = cyc;
        last = cyc;
        n_checks++;
        if (sbq.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious: got sum32=%h, want no result", obs[1].sum);
        end else begin
          exp = sbq.pop_front();
          for (int w = 0; w < 3; w++) begin
            n_checks++;
            if (obs[w] !== exp[w]) begin
              n_fail++; $display("FAIL b2b_result w%0d: got %h, want %h", wid(w), obs[w].sum, exp[w].sum);
            end
          end
        end
      end
      cyc++;
    end
    n_checks++;
    if (n_got != 20 || first != 2 || last != 21) begin
      n_fail++; $display("FAIL b2b_rate: got %0d results cycles %0d..%0d, want 20 results cycles 2..21", n_got, first, last);
    end
  endtask

  task automatic test_sweep;
    logic acc, fire, rdy, c; logic [2:0] ov3; res3_t obs, exp;
    logic [63:0] av, bv;
    int sent, cyc;
    for (int o = 0; o < 4; o++) begin
      sent = 0; cyc = 0;
      while ((sent < 1000 || sbq.size() != 0) && cyc < 5000) begin
        av = {$urandom, $urandom};
        bv = {$urandom, $urandom};
        c  = 1'($urandom);
        case ($urandom_range(0, 7))
          0: av = '1;
          1: bv = '0;
          2: begin av = 64'h7FFF_7FFF_7FFF_7FFF; bv = 64'h0001_0001_0001_0001; end
          3: bv = av;
          default: ;
        endcase
        drive(sent < 1000, av, bv, c, 2'(o), $urandom_range(0, 3) != 0, acc, fire, obs, ov3, rdy);
        cyc++;
        if (acc) sent++;
        if (fire) begin
          n_checks++;
          if (sbq.size() == 0) begin
            n_fail++; $display("FAIL sweep_spurious op%0d: got sum32=%h, want no result", o, obs[1].sum);
          end else begin
            exp = sbq.pop_front();
            for (int w = 0; w < 3; w++) begin
              n_checks++;
              if (obs[w] !== exp[w]) begin
                n_fail++; $display("FAIL sweep op%0d w%0d: got %h c%b o%b z%b s%b, want %h c%b o%b z%b s%b", o, wid(w),
                                   obs[w].sum, obs[w].cout, obs[w].of, obs[w].zero, obs[w].sat,
                                   exp[w].sum, exp[w].cout, exp[w].of, exp[w].zero, exp[w].sat);
              end
            end
          end
        end
      end
      n_checks++;
      if (sent != 1000 || sbq.size() != 0) begin
        n_fail++; $display("FAIL sweep_complete op%0d: got %0d sent %0d pending, want 1000 sent 0 pending", o, sent, sbq.size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset;
    test_directed;
    test_reset_midstream;
    test_backpressure;
    test_back_to_back;
    test_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
